// File: rtl/vga_pkg.sv
// Shared timing constants and coordinate type for the 640x480@60 raster path.
package vga_pkg;

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int PF_X0   = 72;
    localparam int PF_Y0   = 72;
    localparam int PF_W    = 336;
    localparam int PF_H    = 372;
    localparam int TILE    = 12;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/tile_counter.sv
// Pixel-offset counter modulo TILE with a tile index that advances on each offset wrap.
module tile_counter #(
    parameter int TILE  = 12,
    parameter int PX_W  = 4,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    output logic [PX_W-1:0]  px,
    output logic [IDX_W-1:0] idx
);

    localparam logic [PX_W-1:0] PX_LAST = PX_W'(TILE - 1);

    logic [PX_W-1:0]  px_q, px_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        px_d  = px_q;
        idx_d = idx_q;
        if (load) begin
            px_d  = '0;
            idx_d = '0;
        end else if (en) begin
            if (px_q == PX_LAST) begin
                px_d  = '0;
                idx_d = idx_q + IDX_W'(1);
            end else begin
                px_d = px_q + PX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_q  <= '0;
            idx_q <= '0;
        end else begin
            px_q  <= px_d;
            idx_q <= idx_d;
        end
    end

    assign px  = px_q;
    assign idx = idx_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing for the 640x480@60 display path: pixel clock, syncs, blanking,
// pixel coordinates, playfield tile coordinates and a per-frame pulse/counter.
module vga_timing_gen #(
    parameter int H_VIS  = vga_pkg::H_VIS,
    parameter int H_FP   = vga_pkg::H_FP,
    parameter int H_SYNC = vga_pkg::H_SYNC,
    parameter int H_BP   = vga_pkg::H_BP,
    parameter int V_VIS  = vga_pkg::V_VIS,
    parameter int V_FP   = vga_pkg::V_FP,
    parameter int V_SYNC = vga_pkg::V_SYNC,
    parameter int V_BP   = vga_pkg::V_BP,
    parameter int PF_X0  = vga_pkg::PF_X0,
    parameter int PF_Y0  = vga_pkg::PF_Y0,
    parameter int PF_W   = vga_pkg::PF_W,
    parameter int PF_H   = vga_pkg::PF_H,
    parameter int TILE   = vga_pkg::TILE
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        is_playfield,
    output logic [5:0]  tile_col,
    output logic [5:0]  tile_row,
    output logic [3:0]  tile_px,
    output logic [3:0]  tile_py,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    import vga_pkg::*;

    localparam coord_t H_LAST   = coord_t'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t V_LAST   = coord_t'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t HS_START = coord_t'(H_VIS + H_FP);
    localparam coord_t HS_END   = coord_t'(H_VIS + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_VIS + V_FP);
    localparam coord_t VS_END   = coord_t'(V_VIS + V_FP + V_SYNC);
    localparam coord_t H_VIS_C  = coord_t'(H_VIS);
    localparam coord_t V_VIS_C  = coord_t'(V_VIS);
    localparam coord_t PF_X_LO  = coord_t'(PF_X0);
    localparam coord_t PF_X_HI  = coord_t'(PF_X0 + PF_W);
    localparam coord_t PF_Y_LO  = coord_t'(PF_Y0);
    localparam coord_t PF_Y_HI  = coord_t'(PF_Y0 + PF_H);

    if ((PF_X0 + PF_W > H_VIS) || (PF_Y0 + PF_H > V_VIS) ||
        (PF_W % TILE != 0) || (PF_H % TILE != 0)) begin : g_bad_playfield
        $error("vga_timing_gen: playfield must sit inside the visible area and be a whole number of tiles");
    end

    logic          phase_q, phase_d;
    coord_t        hc_q, hc_d;
    coord_t        vc_q, vc_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          blank_n_q, blank_n_d;
    logic          pf_q, pf_d;
    logic          frame_start_q, frame_start_d;
    logic [15:0]   frame_count_q, frame_count_d;

    logic          pix_en;
    logic          h_wrap;
    logic          h_load, h_en, v_load, v_en;

    // Every registered output is decoded from the next (hc, vc) so all of them
    // change on the same edge as DrawX/DrawY.
    always_comb begin
        pix_en  = phase_q;
        phase_d = ~phase_q;
        h_wrap  = pix_en && (hc_q == H_LAST);
        hc_d    = hc_q;
        vc_d    = vc_q;
        if (pix_en) begin
            if (h_wrap) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + coord_t'(1);
            end else begin
                hc_d = hc_q + coord_t'(1);
            end
        end

        hs_d      = !((hc_d >= HS_START) && (hc_d < HS_END));
        vs_d      = !((vc_d >= VS_START) && (vc_d < VS_END));
        blank_n_d = (hc_d < H_VIS_C) && (vc_d < V_VIS_C);
        pf_d      = (hc_d >= PF_X_LO) && (hc_d < PF_X_HI) &&
                    (vc_d >= PF_Y_LO) && (vc_d < PF_Y_HI);

        frame_start_d = h_wrap && (vc_d == V_VIS_C);
        frame_count_d = frame_count_q;
        if (frame_start_d) begin
            frame_count_d = frame_count_q + 16'd1;
        end

        // Tile counters step only while the next position stays inside the
        // playfield, so they keep the last in-field value outside it.
        h_load = pix_en && (hc_d == PF_X_LO);
        h_en   = pix_en && (hc_d > PF_X_LO) && (hc_d < PF_X_HI);
        v_load = h_wrap && (vc_d == PF_Y_LO);
        v_en   = h_wrap && (vc_d > PF_Y_LO) && (vc_d < PF_Y_HI);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            phase_q       <= 1'b0;
            hc_q          <= '0;
            vc_q          <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_n_q     <= 1'b1;
            pf_q          <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            phase_q       <= phase_d;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_n_q     <= blank_n_d;
            pf_q          <= pf_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    tile_counter #(
        .TILE  (TILE),
        .PX_W  (4),
        .IDX_W (6)
    ) u_tile_h (
        .clk  (Clk),
        .rst  (Reset),
        .load (h_load),
        .en   (h_en),
        .px   (tile_px),
        .idx  (tile_col)
    );

    tile_counter #(
        .TILE  (TILE),
        .PX_W  (4),
        .IDX_W (6)
    ) u_tile_v (
        .clk  (Clk),
        .rst  (Reset),
        .load (v_load),
        .en   (v_en),
        .px   (tile_py),
        .idx  (tile_row)
    );

    assign VGA_CLK      = phase_q;
    assign VGA_HS       = hs_q;
    assign VGA_VS       = vs_q;
    assign VGA_BLANK_N  = blank_n_q;
    assign VGA_SYNC_N   = 1'b0;
    assign DrawX        = hc_q;
    assign DrawY        = vc_q;
    assign is_playfield = pf_q;
    assign frame_start  = frame_start_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: raster position model kept as plain integers,
// expected outputs derived from the region rules; vertical jumps use force.
module tb_vga_timing_gen;
    import vga_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
    logic [9:0]  DrawX, DrawY;
    logic        is_playfield;
    logic [5:0]  tile_col, tile_row;
    logic [3:0]  tile_px, tile_py;
    logic        frame_start;
    logic [15:0] frame_count;

    vga_timing_gen dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .VGA_CLK      (VGA_CLK),
        .VGA_HS       (VGA_HS),
        .VGA_VS       (VGA_VS),
        .VGA_BLANK_N  (VGA_BLANK_N),
        .VGA_SYNC_N   (VGA_SYNC_N),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .is_playfield (is_playfield),
        .tile_col     (tile_col),
        .tile_row     (tile_row),
        .tile_px      (tile_px),
        .tile_py      (tile_py),
        .frame_start  (frame_start),
        .frame_count  (frame_count)
    );

    always #10 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: pixel-clock phase, raster position, frame pulse and count
    int m_phase, m_hc, m_vc, m_fs, m_frames;
    logic [9:0] force_vc;

    localparam logic [26:0] RST_VEC = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    logic [26:0] got_vec;
    logic [19:0] got_tile;
    assign got_vec  = {DrawX, DrawY, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK, is_playfield, frame_start, VGA_SYNC_N};
    assign got_tile = {tile_col, tile_px, tile_row, tile_py};

    function automatic void model_reset();
        m_phase = 0; m_hc = 0; m_vc = 0; m_fs = 0; m_frames = 0;
    endfunction

    function automatic void model_edge();
        m_fs = 0;
        if (m_phase == 1) begin
            m_hc = m_hc + 1;
            if (m_hc == H_TOTAL) begin
                m_hc = 0;
                m_vc = (m_vc + 1) % V_TOTAL;
                if (m_vc == V_VIS) begin
                    m_fs = 1;
                    m_frames = (m_frames + 1) % 65536;
                end
            end
        end
        m_phase = 1 - m_phase;
    endfunction

    function automatic logic exp_pf();
        return (m_hc >= PF_X0) && (m_hc < PF_X0 + PF_W) && (m_vc >= PF_Y0) && (m_vc < PF_Y0 + PF_H);
    endfunction

    function automatic logic [26:0] exp_vec();
        logic hs, vs, bl;
        hs = !((m_hc >= H_VIS + H_FP) && (m_hc < H_VIS + H_FP + H_SYNC));
        vs = !((m_vc >= V_VIS + V_FP) && (m_vc < V_VIS + V_FP + V_SYNC));
        bl = (m_hc < H_VIS) && (m_vc < V_VIS);
        return {10'(m_hc), 10'(m_vc), hs, vs, bl, 1'(m_phase), exp_pf(), 1'(m_fs), 1'b0};
    endfunction

    function automatic logic [19:0] exp_tile();
        return {6'((m_hc - PF_X0) / TILE), 4'((m_hc - PF_X0) % TILE),
                6'((m_vc - PF_Y0) / TILE), 4'((m_vc - PF_Y0) % TILE)};
    endfunction

    task automatic tick();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
    endtask

    // Moves the raster to line v mid-line (hc 500, outside sync and playfield).
    task automatic jump_v(input int v);
        int t;
        t = 0;
        while (m_hc != 500 && t < 2000) begin
            tick();
            t++;
        end
        if (m_hc != 500) begin
            n_tests++; n_fail++;
            $display("FAIL jump_sync model hc=%0d required=500", m_hc);
        end
        force_vc = 10'(v);
        force dut.vc_q = force_vc;
        m_vc = v;
        tick();
        release dut.vc_q;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge Clk);
        n_tests++;
        if (got_vec !== RST_VEC) begin
            n_fail++; $display("FAIL reset_outputs got=%h required=%h", got_vec, RST_VEC);
        end
        n_tests++;
        if ({got_tile, frame_count} !== 36'd0) begin
            n_fail++; $display("FAIL reset_tiles_count got=%h/%h required=0", got_tile, frame_count);
        end
    endtask

    task automatic test_line();
        int hs_low, hs_first;
        hs_low = 0; hs_first = -1;
        Reset = 1'b0;
        model_reset();
        tick();
        n_tests++;
        if ({VGA_CLK, DrawX} !== {1'b1, 10'd0}) begin
            n_fail++; $display("FAIL edge1 got clk=%b x=%0d required clk=1 x=0", VGA_CLK, DrawX);
        end
        tick();
        n_tests++;
        if ({VGA_CLK, DrawX} !== {1'b0, 10'd1}) begin
            n_fail++; $display("FAIL edge2 got clk=%b x=%0d required clk=0 x=1", VGA_CLK, DrawX);
        end
        for (int i = 2; i < 1600; i++) begin
            tick();
            n_tests++;
            if (got_vec !== exp_vec()) begin
                n_fail++; $display("FAIL line_timing cyc=%0d got=%h required=%h", i, got_vec, exp_vec());
            end
            if (!VGA_HS) begin
                if (hs_first < 0) hs_first = int'(DrawX);
                hs_low++;
            end
        end
        n_tests++;
        if ({DrawY, DrawX} !== {10'd1, 10'd0}) begin
            n_fail++; $display("FAIL line_wrap got y=%0d x=%0d required y=1 x=0", DrawY, DrawX);
        end
        n_tests++;
        if (hs_low !== 192 || hs_first !== 656) begin
            n_fail++; $display("FAIL hsync_width got low=%0d start=%0d required 192/656", hs_low, hs_first);
        end
    endtask

    task automatic test_playfield();
        int t;
        t = 0;
        jump_v(71);
        while (!(m_vc == 86 && m_hc == 0) && t < 30000) begin
            tick();
            t++;
            n_tests++;
            if (got_vec !== exp_vec()) begin
                n_fail++; $display("FAIL pf_timing got=%h required=%h", got_vec, exp_vec());
            end
            if (exp_pf()) begin
                n_tests++;
                if (got_tile !== exp_tile()) begin
                    n_fail++; $display("FAIL tile_coords x=%0d y=%0d got=%h required=%h", m_hc, m_vc, got_tile, exp_tile());
                end
            end
            if (m_hc == 72 && m_vc == 72) begin
                n_tests++;
                if ({is_playfield, tile_col, tile_px} !== {1'b1, 6'd0, 4'd0}) begin
                    n_fail++; $display("FAIL pix_72_72 got pf=%b col=%0d px=%0d required 1/0/0", is_playfield, tile_col, tile_px);
                end
            end
            if (m_hc == 83 && m_vc == 72) begin
                n_tests++;
                if (tile_px !== 4'd11) begin
                    n_fail++; $display("FAIL pix_83_72 got px=%0d required 11", tile_px);
                end
            end
            if (m_hc == 84 && m_vc == 85) begin
                n_tests++;
                if (got_tile !== {6'd1, 4'd0, 6'd1, 4'd1}) begin
                    n_fail++; $display("FAIL pix_84_85 got=%h required col1 px0 row1 py1", got_tile);
                end
            end
            if (m_vc == 80 && (m_hc == 407 || m_hc == 408)) begin
                n_tests++;
                if (is_playfield !== (m_hc == 407)) begin
                    n_fail++; $display("FAIL pf_right_edge x=%0d got pf=%b", m_hc, is_playfield);
                end
            end
        end
        if (t >= 30000) begin
            n_tests++; n_fail++; $display("FAIL pf_timeout got t=%0d required <30000", t);
        end
    endtask

    task automatic test_frame();
        int t, fs_n, vs_low, vs_first;
        t = 0; fs_n = 0; vs_low = 0; vs_first = -1;
        jump_v(479);
        while (!(m_vc == 482 && m_hc == 0) && t < 8000) begin
            tick();
            t++;
            n_tests++;
            if (got_vec !== exp_vec() || frame_count !== 16'(m_frames)) begin
                n_fail++; $display("FAIL vblank_entry got=%h/%0d required=%h/%0d", got_vec, frame_count, exp_vec(), m_frames);
            end
            if (frame_start) begin
                fs_n++;
                n_tests++;
                if ({DrawY, DrawX} !== {10'd480, 10'd0}) begin
                    n_fail++; $display("FAIL fs_position got y=%0d x=%0d required 480/0", DrawY, DrawX);
                end
            end
        end
        n_tests++;
        if (fs_n !== 1 || frame_count !== 16'd1) begin
            n_fail++; $display("FAIL frame_pulse got pulses=%0d count=%0d required 1/1", fs_n, frame_count);
        end
        t = 0;
        jump_v(489);
        while (!(m_vc == 493 && m_hc == 0) && t < 10000) begin
            tick();
            t++;
            n_tests++;
            if (got_vec !== exp_vec()) begin
                n_fail++; $display("FAIL vsync_timing got=%h required=%h", got_vec, exp_vec());
            end
            if (!VGA_VS) begin
                if (vs_first < 0) vs_first = int'(DrawY);
                vs_low++;
            end
        end
        n_tests++;
        if (vs_low !== 3200 || vs_first !== 490) begin
            n_fail++; $display("FAIL vsync_width got low=%0d first=%0d required 3200/490", vs_low, vs_first);
        end
        t = 0;
        jump_v(523);
        while (!(m_vc == 1 && m_hc == 20) && t < 6000) begin
            tick();
            t++;
            n_tests++;
            if (got_vec !== exp_vec()) begin
                n_fail++; $display("FAIL frame_wrap got=%h required=%h", got_vec, exp_vec());
            end
            if (frame_start) fs_n++;
        end
        n_tests++;
        if (fs_n !== 1 || frame_count !== 16'd1 || t >= 6000) begin
            n_fail++; $display("FAIL wrap_no_pulse got pulses=%0d count=%0d t=%0d required 1/1", fs_n, frame_count, t);
        end
    endtask

    task automatic test_count_wrap();
        int t;
        logic seen;
        t = 0; seen = 1'b0;
        force dut.frame_count_q = 16'hFFFF;
        m_frames = 16'hFFFF;
        tick();
        release dut.frame_count_q;
        jump_v(479);
        while (!seen && t < 5000) begin
            tick();
            t++;
            n_tests++;
            if (got_vec !== exp_vec()) begin
                n_fail++; $display("FAIL count_wrap_timing got=%h required=%h", got_vec, exp_vec());
            end
            if (m_fs == 1) begin
                seen = 1'b1;
                n_tests++;
                if ({frame_start, frame_count} !== {1'b1, 16'h0000}) begin
                    n_fail++; $display("FAIL count_wrap got fs=%b count=%h required 1/0000", frame_start, frame_count);
                end
            end
        end
        if (!seen) begin
            n_tests++; n_fail++; $display("FAIL count_wrap_timeout got no pulse required one");
        end
    endtask

    task automatic test_async_reset();
        int t;
        t = 0;
        while (m_hc != 300 && t < 3000) begin
            tick();
            t++;
        end
        n_tests++;
        if (DrawX !== 10'd300) begin
            n_fail++; $display("FAIL pre_reset_x got=%0d required 300", DrawX);
        end
        #3 Reset = 1'b1;
        #1;
        n_tests++;
        if (got_vec !== RST_VEC || {got_tile, frame_count} !== 36'd0) begin
            n_fail++; $display("FAIL async_reset got=%h tiles=%h count=%h required=%h/0/0", got_vec, got_tile, frame_count, RST_VEC);
        end
        @(posedge Clk);
        @(negedge Clk);
        n_tests++;
        if (got_vec !== RST_VEC) begin
            n_fail++; $display("FAIL reset_hold got=%h required=%h", got_vec, RST_VEC);
        end
        Reset = 1'b0;
        model_reset();
        for (int i = 0; i < 24; i++) begin
            tick();
            n_tests++;
            if (got_vec !== exp_vec() || frame_count !== 16'd0) begin
                n_fail++; $display("FAIL restart cyc=%0d got=%h required=%h", i, got_vec, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        force_vc = '0;
        test_reset();
        test_line();
        test_playfield();
        test_frame();
        test_count_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
